// File: rtl/handshake_source.sv
// Burst transmitter on the producer side of a valid/ready stream: emits an
// arithmetic sequence of beats with an optional idle gap, honouring backpressure.
module handshake_source #(
    parameter int VALUE_BITS = 8,
    parameter int COUNT_BITS = 8,
    parameter int GAP_BITS   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic [VALUE_BITS-1:0] i_base,
    input  logic [VALUE_BITS-1:0] i_step,
    input  logic [COUNT_BITS-1:0] i_count,
    input  logic [GAP_BITS-1:0]   i_gap,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [COUNT_BITS-1:0] o_sent,
    output logic [VALUE_BITS-1:0] o_value,
    output logic                  o_valid,
    input  logic                  i_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                  state_r, state_s;
    logic [VALUE_BITS-1:0]   value_r, value_s;
    logic [VALUE_BITS-1:0]   step_r, step_s;
    logic [COUNT_BITS-1:0]   count_r, count_s;
    logic [COUNT_BITS-1:0]   sent_r, sent_s;
    logic [GAP_BITS-1:0]     gap_r, gap_s;
    logic [GAP_BITS-1:0]     gap_cnt_r, gap_cnt_s;
    logic                    valid_r, valid_s;
    logic                    busy_r, busy_s;
    logic                    done_r, done_s;
    logic                    xfer_s;
    logic                    last_s;

    // Next-state and next-output logic for the burst FSM
    always_comb begin
        state_s   = state_r;
        value_s   = value_r;
        step_s    = step_r;
        count_s   = count_r;
        sent_s    = sent_r;
        gap_s     = gap_r;
        gap_cnt_s = gap_cnt_r;
        valid_s   = valid_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        xfer_s    = valid_r & i_ready;
        last_s    = ((sent_r + COUNT_BITS'(1)) == count_r);

        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    step_s  = i_step;
                    count_s = i_count;
                    gap_s   = i_gap;
                    sent_s  = '0;
                    busy_s  = 1'b1;
                    if (i_count != '0) begin
                        value_s = i_base;
                        valid_s = 1'b1;
                        state_s = ST_SEND;
                    end else begin
                        done_s  = 1'b1;
                        state_s = ST_DONE;
                    end
                end else begin
                    busy_s  = 1'b0;
                    valid_s = 1'b0;
                end
            end
            ST_SEND: begin
                if (xfer_s) begin
                    sent_s = sent_r + COUNT_BITS'(1);
                    if (last_s) begin
                        valid_s = 1'b0;
                        done_s  = 1'b1;
                        state_s = ST_DONE;
                    end else begin
                        value_s = value_r + step_r;
                        if (gap_r == '0) begin
                            valid_s = 1'b1;
                        end else begin
                            valid_s   = 1'b0;
                            gap_cnt_s = gap_r;
                            state_s   = ST_GAP;
                        end
                    end
                end else begin
                    valid_s = 1'b1;
                end
            end
            ST_GAP: begin
                // Valid rises on the edge that ends the last idle cycle
                if (gap_cnt_r <= GAP_BITS'(1)) begin
                    valid_s = 1'b1;
                    state_s = ST_SEND;
                end else begin
                    gap_cnt_s = gap_cnt_r - GAP_BITS'(1);
                end
            end
            ST_DONE: begin
                busy_s  = 1'b0;
                valid_s = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                valid_s = 1'b0;
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            value_r   <= '0;
            step_r    <= '0;
            count_r   <= '0;
            sent_r    <= '0;
            gap_r     <= '0;
            gap_cnt_r <= '0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            value_r   <= value_s;
            step_r    <= step_s;
            count_r   <= count_s;
            sent_r    <= sent_s;
            gap_r     <= gap_s;
            gap_cnt_r <= gap_cnt_s;
            valid_r   <= valid_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign o_value = value_r;
    assign o_valid = valid_r;
    assign o_busy  = busy_r;
    assign o_done  = done_r;
    assign o_sent  = sent_r;

endmodule

// File: tb/tb_handshake_source.sv
// Directed bench for handshake_source: scoreboard of expected beat values plus
// cycle-exact checks of valid timing, gaps, done pulse and reset behaviour.
module tb_handshake_source;

    logic       clock;
    logic       reset;
    logic       i_start;
    logic [7:0] i_base;
    logic [7:0] i_step;
    logic [7:0] i_count;
    logic [3:0] i_gap;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_sent;
    logic [7:0] o_value;
    logic       o_valid;
    logic       i_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];
    logic       prev_hold  = 1'b0;
    logic [7:0] prev_value = 8'd0;

    handshake_source dut (
        .clock   (clock),
        .reset   (reset),
        .i_start (i_start),
        .i_base  (i_base),
        .i_step  (i_step),
        .i_count (i_count),
        .i_gap   (i_gap),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_sent  (o_sent),
        .o_value (o_value),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive an accepted start for one edge and record its beat values
    task automatic start_burst(input logic [7:0] base, input logic [7:0] step,
                               input logic [7:0] count, input logic [3:0] gap);
        logic [7:0] v;
        v = base;
        for (int i = 0; i < int'(count); i++) begin
            exp_q.push_back(v);
            v = v + step;
        end
        i_start = 1'b1;
        i_base  = base;
        i_step  = step;
        i_count = count;
        i_gap   = gap;
        tick();
        i_start = 1'b0;
    endtask

    // Scoreboard and backpressure-stability monitor, sampled mid-cycle
    always @(negedge clock) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", {31'd0, o_valid}, 32'd1);
                check("hold_value", {24'd0, o_value}, {24'd0, prev_value});
            end
            if (o_valid && i_ready) begin
                check("beat_expected", {31'd0, (exp_q.size() != 0)}, 32'd1);
                if (exp_q.size() != 0) begin
                    check("beat_value", {24'd0, o_value}, {24'd0, exp_q.pop_front()});
                end
            end
            prev_hold  = o_valid && !i_ready;
            prev_value = o_value;
        end
    end

    task automatic run_b2b(input string tag);
        i_ready = 1'b1;
        start_burst(8'h10, 8'h01, 8'd4, 4'd0);
        check({tag, "_busy"}, {31'd0, o_busy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
            check({tag, "_value"}, {24'd0, o_value}, 32'h10 + i);
            tick();
        end
        check({tag, "_done"}, {31'd0, o_done}, 32'd1);
        check({tag, "_valid_low"}, {31'd0, o_valid}, 32'd0);
        check({tag, "_sent"}, {24'd0, o_sent}, 32'd4);
        tick();
        check({tag, "_done_clear"}, {31'd0, o_done}, 32'd0);
        check({tag, "_busy_clear"}, {31'd0, o_busy}, 32'd0);
        check({tag, "_sent_hold"}, {24'd0, o_sent}, 32'd4);
        check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        logic       seen_done;
        logic [3:0] gap_valid;
        logic [7:0] gap_vals;

        reset   = 1'b1;
        i_start = 1'b0;
        i_base  = 8'd0;
        i_step  = 8'd0;
        i_count = 8'd0;
        i_gap   = 4'd0;
        i_ready = 1'b0;
        tick();
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_value", {24'd0, o_value}, 32'd0);
        check("rst_busy",  {31'd0, o_busy},  32'd0);
        check("rst_done",  {31'd0, o_done},  32'd0);
        check("rst_sent",  {24'd0, o_sent},  32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Scenario 1: back-to-back
        run_b2b("b2b");

        // Scenario 2: backpressure with ready pattern 1,0,0
        i_ready = 1'b0;
        start_burst(8'h10, 8'h01, 8'd4, 4'd0);
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            i_ready = ((k % 3) == 0);
            tick();
            if (o_done) begin
                seen_done = 1'b1;
                break;
            end
        end
        check("bp_done_seen", {31'd0, seen_done}, 32'd1);
        check("bp_sent", {24'd0, o_sent}, 32'd4);
        check("bp_queue_empty", exp_q.size(), 32'd0);
        i_ready = 1'b0;
        tick();

        // Scenario 3: gap of 2 with wrap-around
        i_ready = 1'b1;
        start_burst(8'hFE, 8'h03, 8'd3, 4'd2);
        for (int c = 0; c < 7; c++) begin
            check("gap_valid", {31'd0, o_valid}, {31'd0, ((c % 3) == 0)});
            if ((c % 3) == 0) begin
                gap_vals = 8'hFE + 8'(3 * (c / 3));
                check("gap_value", {24'd0, o_value}, {24'd0, gap_vals});
            end
            tick();
        end
        check("gap_done", {31'd0, o_done}, 32'd1);
        check("gap_sent", {24'd0, o_sent}, 32'd3);
        tick();
        check("gap_queue_empty", exp_q.size(), 32'd0);

        // Scenario 4: zero-count burst
        start_burst(8'h55, 8'h01, 8'd0, 4'd0);
        check("zero_valid", {31'd0, o_valid}, 32'd0);
        check("zero_done",  {31'd0, o_done},  32'd1);
        check("zero_busy",  {31'd0, o_busy},  32'd1);
        check("zero_sent",  {24'd0, o_sent},  32'd0);
        tick();
        check("zero_done_clear", {31'd0, o_done}, 32'd0);
        check("zero_busy_clear", {31'd0, o_busy}, 32'd0);
        check("zero_valid_low",  {31'd0, o_valid}, 32'd0);

        // Scenario 5: start while busy is ignored; start in first IDLE cycle accepted
        i_ready = 1'b0;
        start_burst(8'h40, 8'h02, 8'd3, 4'd0);
        i_start = 1'b1;
        i_base  = 8'h99;
        i_step  = 8'h07;
        i_count = 8'd5;
        i_gap   = 4'd3;
        tick();
        i_start = 1'b0;
        check("busy_start_value", {24'd0, o_value}, 32'h40);
        check("busy_start_sent",  {24'd0, o_sent},  32'd0);
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("busy_seq_valid", {31'd0, o_valid}, 32'd1);
            check("busy_seq_value", {24'd0, o_value}, 32'h40 + 2 * i);
            tick();
        end
        check("busy_seq_done", {31'd0, o_done}, 32'd1);
        check("busy_seq_sent", {24'd0, o_sent}, 32'd3);
        tick();
        check("idle_done_clear", {31'd0, o_done}, 32'd0);
        start_burst(8'h80, 8'h01, 8'd1, 4'd0);
        check("restart_valid", {31'd0, o_valid}, 32'd1);
        check("restart_value", {24'd0, o_value}, 32'h80);
        check("restart_sent",  {24'd0, o_sent},  32'd0);
        tick();
        check("restart_done", {31'd0, o_done}, 32'd1);
        check("restart_sent_final", {24'd0, o_sent}, 32'd1);
        tick();
        check("restart_queue_empty", exp_q.size(), 32'd0);

        // Scenario 6: reset mid-burst under backpressure
        i_ready = 1'b0;
        start_burst(8'h20, 8'h05, 8'd5, 4'd1);
        check("mid_valid", {31'd0, o_valid}, 32'd1);
        reset = 1'b1;
        tick();
        exp_q.delete();
        check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        check("mid_rst_value", {24'd0, o_value}, 32'd0);
        check("mid_rst_busy",  {31'd0, o_busy},  32'd0);
        check("mid_rst_done",  {31'd0, o_done},  32'd0);
        check("mid_rst_sent",  {24'd0, o_sent},  32'd0);
        reset = 1'b0;
        run_b2b("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
